// File: rtl/idu_decode_stage.sv
// RV32I(+M) registered decode stage: full opcode/funct3/funct7 decode into one
// instruction number, 2-entry skid buffer between valid/ready ports, illegal counter.
package idu_pkg;
   localparam int INST_NUM_W = 6;

   localparam logic [INST_NUM_W-1:0]
      NUM_INV    = 6'd0,
      NUM_LUI    = 6'd1,  NUM_AUIPC  = 6'd2,  NUM_JAL    = 6'd3,  NUM_JALR   = 6'd4,
      NUM_BEQ    = 6'd5,  NUM_BNE    = 6'd6,  NUM_BLT    = 6'd7,  NUM_BGE    = 6'd8,
      NUM_BLTU   = 6'd9,  NUM_BGEU   = 6'd10,
      NUM_LB     = 6'd11, NUM_LH     = 6'd12, NUM_LW     = 6'd13, NUM_LBU    = 6'd14,
      NUM_LHU    = 6'd15,
      NUM_SB     = 6'd16, NUM_SH     = 6'd17, NUM_SW     = 6'd18,
      NUM_ADDI   = 6'd19, NUM_SLTI   = 6'd20, NUM_SLTIU  = 6'd21, NUM_XORI   = 6'd22,
      NUM_ORI    = 6'd23, NUM_ANDI   = 6'd24, NUM_SLLI   = 6'd25, NUM_SRLI   = 6'd26,
      NUM_SRAI   = 6'd27,
      NUM_ADD    = 6'd28, NUM_SUB    = 6'd29, NUM_SLL    = 6'd30, NUM_SLT    = 6'd31,
      NUM_SLTU   = 6'd32, NUM_XOR    = 6'd33, NUM_SRL    = 6'd34, NUM_SRA    = 6'd35,
      NUM_OR     = 6'd36, NUM_AND    = 6'd37,
      NUM_ECALL  = 6'd38, NUM_EBREAK = 6'd39,
      NUM_MUL    = 6'd40, NUM_MULH   = 6'd41, NUM_MULHSU = 6'd42, NUM_MULHU  = 6'd43,
      NUM_DIV    = 6'd44, NUM_DIVU   = 6'd45, NUM_REM    = 6'd46, NUM_REMU   = 6'd47;
endpackage

module idu_decoder
   import idu_pkg::*;
#(
   parameter bit EN_MUL = 1'b0
) (
   input  logic [31:0]           inst,
   output logic [INST_NUM_W-1:0] num,
   output logic                  illegal
);
   logic [6:0] opc;
   logic [2:0] f3;
   logic [6:0] f7;

   assign opc = inst[6:0];
   assign f3  = inst[14:12];
   assign f7  = inst[31:25];

   always_comb begin
      num = NUM_INV;
      case (opc)
         7'b0110111: num = NUM_LUI;
         7'b0010111: num = NUM_AUIPC;
         7'b1101111: num = NUM_JAL;
         7'b1100111: if (f3 == 3'b000) num = NUM_JALR;
         7'b1100011: begin
            case (f3)
               3'b000:  num = NUM_BEQ;
               3'b001:  num = NUM_BNE;
               3'b100:  num = NUM_BLT;
               3'b101:  num = NUM_BGE;
               3'b110:  num = NUM_BLTU;
               3'b111:  num = NUM_BGEU;
               default: num = NUM_INV;
            endcase
         end
         7'b0000011: begin
            case (f3)
               3'b000:  num = NUM_LB;
               3'b001:  num = NUM_LH;
               3'b010:  num = NUM_LW;
               3'b100:  num = NUM_LBU;
               3'b101:  num = NUM_LHU;
               default: num = NUM_INV;
            endcase
         end
         7'b0100011: begin
            case (f3)
               3'b000:  num = NUM_SB;
               3'b001:  num = NUM_SH;
               3'b010:  num = NUM_SW;
               default: num = NUM_INV;
            endcase
         end
         7'b0010011: begin
            case (f3)
               3'b000:  num = NUM_ADDI;
               3'b010:  num = NUM_SLTI;
               3'b011:  num = NUM_SLTIU;
               3'b100:  num = NUM_XORI;
               3'b110:  num = NUM_ORI;
               3'b111:  num = NUM_ANDI;
               3'b001:  if (f7 == 7'b0000000) num = NUM_SLLI;
               3'b101: begin
                  if (f7 == 7'b0000000)      num = NUM_SRLI;
                  else if (f7 == 7'b0100000) num = NUM_SRAI;
               end
               default: num = NUM_INV;
            endcase
         end
         7'b0110011: begin
            if (f7 == 7'b0000000) begin
               case (f3)
                  3'b000:  num = NUM_ADD;
                  3'b001:  num = NUM_SLL;
                  3'b010:  num = NUM_SLT;
                  3'b011:  num = NUM_SLTU;
                  3'b100:  num = NUM_XOR;
                  3'b101:  num = NUM_SRL;
                  3'b110:  num = NUM_OR;
                  default: num = NUM_AND;
               endcase
            end else if (f7 == 7'b0100000) begin
               if (f3 == 3'b000)      num = NUM_SUB;
               else if (f3 == 3'b101) num = NUM_SRA;
            end else if (f7 == 7'b0000001 && EN_MUL) begin
               // M-extension codes are contiguous in funct3 order
               num = NUM_MUL + {3'b000, f3};
            end
         end
         7'b1110011: begin
            if (inst == 32'h0000_0073)      num = NUM_ECALL;
            else if (inst == 32'h0010_0073) num = NUM_EBREAK;
         end
         default: num = NUM_INV;
      endcase
   end

   assign illegal = (num == NUM_INV);
endmodule

module idu_decode_stage
   import idu_pkg::*;
#(
   parameter int ISA_WIDTH     = 32,
   parameter int NUM_WIDTH     = INST_NUM_W,
   parameter bit EN_MUL        = 1'b0,
   parameter int ILL_CNT_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ISA_WIDTH-1:0]     in_inst,
   input  logic [ISA_WIDTH-1:0]     in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ISA_WIDTH-1:0]     out_inst,
   output logic [ISA_WIDTH-1:0]     out_pc,
   output logic [NUM_WIDTH-1:0]     out_inst_num,
   output logic                     out_illegal,
   output logic [ILL_CNT_WIDTH-1:0] ill_cnt
);
   typedef struct packed {
      logic [ISA_WIDTH-1:0] inst;
      logic [ISA_WIDTH-1:0] pc;
      logic [NUM_WIDTH-1:0] num;
      logic                 illegal;
   } ent_t;

   logic [INST_NUM_W-1:0] dec_num;
   logic                  dec_illegal;
   ent_t                  dec_ent;
   ent_t                  mem [2];
   ent_t                  head;
   logic                  wr_ptr, rd_ptr;
   logic [1:0]            cnt;
   logic                  push, pop;

   idu_decoder #(.EN_MUL(EN_MUL)) u_dec (
      .inst    (in_inst[31:0]),
      .num     (dec_num),
      .illegal (dec_illegal)
   );

   always_comb begin
      dec_ent         = '0;
      dec_ent.inst    = in_inst;
      dec_ent.pc      = in_pc;
      dec_ent.num     = NUM_WIDTH'(dec_num);
      dec_ent.illegal = dec_illegal;
   end

   // in_ready depends on registered count only, so no out_ready -> in_ready path
   assign in_ready  = (cnt != 2'd2);
   assign out_valid = (cnt != 2'd0);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem[0]  <= '0;
         mem[1]  <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         cnt     <= 2'd0;
         ill_cnt <= '0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= dec_ent;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
         if (push && dec_illegal && !(&ill_cnt))
            ill_cnt <= ill_cnt + ILL_CNT_WIDTH'(1);
      end
   end

   assign head         = mem[rd_ptr];
   assign out_inst     = head.inst;
   assign out_pc       = head.pc;
   assign out_inst_num = head.num;
   // stale entry contents are harmless when empty, but illegal must read 0
   assign out_illegal  = out_valid & head.illegal;
endmodule

// File: doc/idu_decode_stage.md
# idu_decode_stage

Registered, parametrised RV32I(+M) instruction decode stage for the NPC IDU. It supersedes the per-field combinational funct3 lookup by decoding opcode, funct3 and funct7 together into one instruction number. Instructions enter and leave through valid/ready handshakes, with a 2-entry skid buffer in between. The block also flags illegal encodings and keeps a saturating count of them for the EXU and the difftest harness.

## Interface
Parameters:
- `ISA_WIDTH`, default `ISA_WIDTH (32): instruction and PC width; must be 32.
- `NUM_WIDTH`, default `INST_NUM_WIDTH: width of the instruction-number code, using the config.v enumeration (`inv, `lui, `auipc, `jal, `jalr, `beq … `bgeu, `lb … `lhu, `sb/`sh/`sw, `addi … `srai, `add … `and, `ecall, `ebreak, `mul … `remu).
- `EN_MUL`, default 0: 1 enables M-extension decode; 0 makes funct7=0000001 OP encodings illegal.
- `ILL_CNT_WIDTH`, default 16: width of the illegal-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  **asynchronous, active-low reset.**
- flush  in  1  synchronous; empties the buffer.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction.
- in_inst  in  ISA_WIDTH  instruction word.
- in_pc  in  ISA_WIDTH  PC of in_inst.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  downstream accepts.
- out_inst  out  ISA_WIDTH  instruction word, passed through.
- out_pc  out  ISA_WIDTH  PC, passed through.
- out_inst_num  out  NUM_WIDTH  decoded code; `inv if illegal.
- out_illegal  out  1  high when out_inst_num == `inv.
- ill_cnt  out  ILL_CNT_WIDTH  saturating count of accepted illegal instructions.

## Operation
- Push happens when in_valid & in_ready. Pop happens when out_valid & out_ready. The buffer has 2 entries, is FIFO-ordered, and holds {inst, pc, inst_num, illegal} per entry.
- Decoding is combinational on in_inst, and the result is stored at push time. Fields: opc=[6:0], f3=[14:12], f7=[31:25].
- Decode by opcode:
  - 0110111 decodes as lui. 0010111 decodes as auipc. 1101111 decodes as jal.
  - 1100111 decodes as jalr only when f3=000.
  - 1100011 (branch): f3 000/001/100/101/110/111 decode as beq/bne/blt/bge/bltu/bgeu; 010 and 011 are illegal.
  - 0000011 (load): f3 000/001/010/100/101 decode as lb/lh/lw/lbu/lhu; other f3 values are illegal.
  - 0100011 (store): f3 000/001/010 decode as sb/sh/sw; other f3 values are illegal.
  - 0010011 (op-imm): f3 000/010/011/100/110/111 decode as addi/slti/sltiu/xori/ori/andi.
    - f3 001 decodes as slli only when f7=0000000.
    - f3 101 decodes as srli when f7=0000000 and as srai when f7=0100000.
  - 0110011 (op), split by f7:
    - f7=0000000: add/sll/slt/sltu/xor/srl/or/and by f3.
    - f7=0100000: f3 000 decodes as sub and f3 101 as sra; other f3 values are illegal.
    - f7=0000001 with EN_MUL=1: mul/mulh/mulhsu/mulhu/div/divu/rem/remu by f3.
  - 1110011 (system): the whole word 0x00000073 decodes as ecall and 0x00100073 as ebreak; every other system word is illegal.
  - Any other opcode, and any unlisted combination, decodes as `inv with illegal=1.
- in_ready = (count < 2). It comes from registered count only and has no combinational path from out_ready.
- Head entry drives out_*. out_valid = (count != 0).
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged, and order is preserved.
- ill_cnt increments by 1 on each push whose illegal bit is 1. It saturates at all-ones.
- flush takes priority over push and pop in the same cycle:
  - count goes to 0 and the same-cycle input is dropped.
  - ill_cnt is not changed, including for the dropped input.

## Timing
- Reset (rst=0, asynchronous) sets:
  - count=0, out_valid=0, in_ready=1.
  - out_inst=0, out_pc=0, out_inst_num=`inv, out_illegal=0.
  - ill_cnt=0.
- Reset release is sampled at the next clk edge. Reset asserted mid-stream discards all buffered entries immediately.
- Latency is 1 cycle: an instruction pushed at edge k appears on out_* from edge k onward, so it can pop at edge k+1.
- Throughput is 1 instruction per cycle with out_ready held at 1.
- With out_ready=0, two pushes fill the buffer. in_ready drops in the cycle after the second push.
- out_* must stay stable while out_valid=1 and out_ready=0.
- In the empty state, out_inst, out_pc and out_inst_num are don't-care, but out_illegal must be 0.

## Test plan
- Reset then stream with out_ready=1: push 0x00000063, 0x00002003, 0x00002023, 0x00100073 on consecutive cycles. Required: out_inst_num = `beq, `lw, `sw, `ebreak, one cycle later each, with PCs matching.
- Backpressure: out_ready=0 and 3 pushes attempted. Required: 2 accepted, in_ready=0, and the third is held off by the source. Then out_ready=1: outputs drain in order with no loss or duplication.
- OP/M decode:
  - 0x40000033 decodes as `sub.
  - 0x02000033 decodes as `mul when EN_MUL=1.
  - 0x02000033 decodes as `inv with out_illegal=1 and ill_cnt=1 when EN_MUL=0.
- Illegal saturation, using ILL_CNT_WIDTH=2: push 5 words of 0xFFFFFFFF. Required: ill_cnt sequence is 1, 2, 3, 3, 3.
- Flush with buffer full plus a simultaneous push: next cycle count=0 and out_valid=0. The dropped word never appears on out_* and ill_cnt is unchanged.
- Asynchronous reset mid-stream with 2 entries buffered: out_valid falls without waiting for a clock edge. After release, the first new push is the first output.
